// File: rtl/snake_move.sv
// Snake body engine for the 16x16 playfield: moves the head, shifts the body,
// grows or shrinks it and flags wall, self, food and poison collisions.
module snake_move #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       state,
  input  logic             step,
  input  logic [1:0]       dir,
  input  logic             dir_valid,
  input  logic [3:0]       food_x,
  input  logic [3:0]       food_y,
  input  logic [3:0]       poison_x,
  input  logic [3:0]       poison_y,
  input  logic [LEN_W-1:0] seg_idx,
  output logic [3:0]       head_x,
  output logic [3:0]       head_y,
  output logic [LEN_W-1:0] length,
  output logic [3:0]       seg_x,
  output logic [3:0]       seg_y,
  output logic             seg_valid,
  output logic             TouchFood,
  output logic             TouchPoison,
  output logic             dead
);

  localparam logic [2:0] PLAY = 3'b010;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  logic [3:0]       r_segX [MAX_LEN];
  logic [3:0]       r_segY [MAX_LEN];
  logic [LEN_W-1:0] r_length;
  dir_t             r_curDir;
  dir_t             r_pendDir;
  logic             r_touchFood;
  logic             r_touchPoison;
  logic             r_dead;

  logic [3:0]       w_candX;
  logic [3:0]       w_candY;
  logic             w_wall;
  logic             w_self;
  logic             w_move;
  logic             w_hitPoison;
  logic             w_hitFood;
  logic             w_dirAccept;

  // Up/down and left/right differ only in bit 0, so the reverse flips it.
  function automatic dir_t reverseOf(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

  assign w_move      = (state == PLAY) && step && !r_dead;
  assign w_dirAccept = dir_valid && (dir_t'(dir) != reverseOf(r_curDir));
  assign w_hitPoison = (w_candX == poison_x) && (w_candY == poison_y);
  assign w_hitFood   = (w_candX == food_x) && (w_candY == food_y);

  always_comb begin
    w_candX = r_segX[0];
    w_candY = r_segY[0];
    w_wall  = 1'b0;
    case (r_pendDir)
      DIR_UP:    if (r_segY[0] == 4'd0)  w_wall = 1'b1; else w_candY = r_segY[0] - 4'd1;
      DIR_DOWN:  if (r_segY[0] == 4'd15) w_wall = 1'b1; else w_candY = r_segY[0] + 4'd1;
      DIR_LEFT:  if (r_segX[0] == 4'd0)  w_wall = 1'b1; else w_candX = r_segX[0] - 4'd1;
      default:   if (r_segX[0] == 4'd15) w_wall = 1'b1; else w_candX = r_segX[0] + 4'd1;
    endcase
  end

  // The tail (index length-1) is excluded because it vacates on this move.
  always_comb begin
    w_self = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i + 2) <= int'(r_length) && r_segX[i] == w_candX && r_segY[i] == w_candY)
        w_self = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_segX[i] <= (i < 3) ? 4'(2 - i) : 4'd0;
        r_segY[i] <= (i < 3) ? 4'd8 : 4'd0;
      end
      r_length      <= LEN_W'(3);
      r_curDir      <= DIR_RIGHT;
      r_pendDir     <= DIR_RIGHT;
      r_touchFood   <= 1'b0;
      r_touchPoison <= 1'b0;
      r_dead        <= 1'b0;
    end else begin
      r_touchFood   <= 1'b0;
      r_touchPoison <= 1'b0;
      if (w_dirAccept)
        r_pendDir <= dir_t'(dir);
      if (w_move) begin
        if (w_wall || w_self) begin
          r_dead <= 1'b1;
        end else begin
          // Shifting runs through unused slots so the old tail survives growth.
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            r_segX[i] <= r_segX[i-1];
            r_segY[i] <= r_segY[i-1];
          end
          r_segX[0] <= w_candX;
          r_segY[0] <= w_candY;
          r_curDir  <= r_pendDir;
          if (w_hitPoison) begin
            r_touchPoison <= 1'b1;
            if (r_length == LEN_W'(1))
              r_dead <= 1'b1;
            else
              r_length <= r_length - LEN_W'(1);
          end else if (w_hitFood) begin
            r_touchFood <= 1'b1;
            if (r_length != LEN_W'(MAX_LEN))
              r_length <= r_length + LEN_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    seg_x = 4'd0;
    seg_y = 4'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (seg_idx == LEN_W'(i)) begin
        seg_x = r_segX[i];
        seg_y = r_segY[i];
      end
    end
  end

  assign seg_valid   = seg_idx < r_length;
  assign head_x      = r_segX[0];
  assign head_y      = r_segY[0];
  assign length      = r_length;
  assign TouchFood   = r_touchFood;
  assign TouchPoison = r_touchPoison;
  assign dead        = r_dead;

endmodule

// File: tb/tb_snake_move.sv
// Scoreboard bench for snake_move: a queue-based snake model predicts every
// step's outcome; a negedge monitor pops and compares the DUT's response.
module tb_snake_move;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       state = 3'b000;
  logic             step = 1'b0;
  logic [1:0]       dir = 2'b00;
  logic             dir_valid = 1'b0;
  logic [3:0]       food_x = 4'd15, food_y = 4'd15;
  logic [3:0]       poison_x = 4'd15, poison_y = 4'd0;
  logic [LEN_W-1:0] seg_idx = '0;
  logic [3:0]       head_x, head_y, seg_x, seg_y;
  logic [LEN_W-1:0] length;
  logic             seg_valid, TouchFood, TouchPoison, dead;

  snake_move #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .state(state), .step(step), .dir(dir),
    .dir_valid(dir_valid), .food_x(food_x), .food_y(food_y),
    .poison_x(poison_x), .poison_y(poison_y), .seg_idx(seg_idx),
    .head_x(head_x), .head_y(head_y), .length(length), .seg_x(seg_x),
    .seg_y(seg_y), .seg_valid(seg_valid), .TouchFood(TouchFood),
    .TouchPoison(TouchPoison), .dead(dead)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hx, hy, len;
    int dd, tf, tp;
    logic [8*MAX_LEN-1:0] body;
  } exp_t;

  exp_t expQ[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  // Model: body as a queue of {x,y} cells, head at the front.
  logic [7:0] mBody[$];
  int   mCur, mPend, mDead;
  logic stepD = 1'b0;

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic modelReset();
    mBody = {};
    mBody.push_back(8'h28);
    mBody.push_back(8'h18);
    mBody.push_back(8'h08);
    mCur = 3; mPend = 3; mDead = 0;
  endtask

  task automatic aheadOf(output int ax, output int ay);
    ax = int'(mBody[0][7:4]);
    ay = int'(mBody[0][3:0]);
    case (mPend)
      0: ay--;
      1: ay++;
      2: ax--;
      default: ax++;
    endcase
  endtask

  task automatic applyStimulus(input int st, input int stp, input int dv, input int d,
                               input int fx, input int fy, input int px, input int py);
    exp_t e;
    int nx, ny, oldSize, prevCur;
    bit hitWall, hitSelf;
    logic [7:0] c;
    @(posedge clk);
    #1;
    state = 3'(st); step = 1'(stp); dir_valid = 1'(dv); dir = 2'(d);
    food_x = 4'(fx); food_y = 4'(fy); poison_x = 4'(px); poison_y = 4'(py);
    e.tf = 0; e.tp = 0;
    prevCur = mCur;
    if (stp != 0 && st == 2 && mDead == 0) begin
      aheadOf(nx, ny);
      hitWall = nx < 0 || nx > 15 || ny < 0 || ny > 15;
      c = {nx[3:0], ny[3:0]};
      hitSelf = 1'b0;
      for (int i = 1; i <= mBody.size() - 2; i++)
        if (mBody[i] == c) hitSelf = 1'b1;
      if (hitWall || hitSelf) begin
        mDead = 1;
      end else begin
        oldSize = mBody.size();
        mBody.push_front(c);
        mCur = mPend;
        if (nx == px && ny == py) begin
          e.tp = 1;
          void'(mBody.pop_back());
          if (oldSize > 1) void'(mBody.pop_back());
          else mDead = 1;
        end else if (nx == fx && ny == fy) begin
          e.tf = 1;
          if (oldSize == MAX_LEN) void'(mBody.pop_back());
        end else begin
          void'(mBody.pop_back());
        end
      end
    end
    if (dv != 0 && d != opposite(prevCur)) mPend = d;
    if (stp != 0) begin
      e.hx = int'(mBody[0][7:4]);
      e.hy = int'(mBody[0][3:0]);
      e.len = mBody.size();
      e.dd = mDead;
      e.body = '0;
      for (int i = 0; i < mBody.size(); i++) e.body[8*i +: 8] = mBody[i];
      expQ.push_back(e);
    end
  endtask

  task automatic checkResetImage(input string tag);
    checkOutput({tag, "_headX"}, int'(head_x), 2);
    checkOutput({tag, "_headY"}, int'(head_y), 8);
    checkOutput({tag, "_length"}, int'(length), 3);
    checkOutput({tag, "_dead"}, int'(dead), 0);
    checkOutput({tag, "_food"}, int'(TouchFood), 0);
    checkOutput({tag, "_poison"}, int'(TouchPoison), 0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 step = 1'b0; dir_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
    #2 checkResetImage("reset");
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic asyncResetCheck();
    @(posedge clk);
    #1 step = 1'b0; dir_valid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    modelReset();
    #1 checkResetImage("asyncReset");
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  always @(posedge clk) stepD <= step;

  always @(negedge clk) begin
    exp_t e;
    int k;
    if (stepD) begin
      if (expQ.size() == 0) begin
        checkOutput("scoreboardUnderflow", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("headX", int'(head_x), e.hx);
        checkOutput("headY", int'(head_y), e.hy);
        checkOutput("length", int'(length), e.len);
        checkOutput("dead", int'(dead), e.dd);
        checkOutput("touchFood", int'(TouchFood), e.tf);
        checkOutput("touchPoison", int'(TouchPoison), e.tp);
        k = int'($urandom_range(0, MAX_LEN + 3));
        seg_idx = LEN_W'(k);
        #1;
        checkOutput("segValid", int'(seg_valid), (k < e.len) ? 1 : 0);
        if (k < e.len) begin
          checkOutput("segX", int'(seg_x), int'(e.body[8*k+4 +: 4]));
          checkOutput("segY", int'(seg_y), int'(e.body[8*k +: 4]));
        end else if (k >= MAX_LEN) begin
          checkOutput("segXOutOfRange", int'(seg_x), 0);
          checkOutput("segYOutOfRange", int'(seg_y), 0);
        end
      end
    end else begin
      checkOutput("idleFood", int'(TouchFood), 0);
      checkOutput("idlePoison", int'(TouchPoison), 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fx, fy, px, py, ax, ay, st, stp;
    modelReset();

    // Plain movement to the right.
    doReset();
    repeat (3) applyStimulus(2, 1, 0, 0, 15, 15, 15, 0);

    // Food directly ahead.
    doReset();
    applyStimulus(2, 1, 0, 0, 3, 8, 15, 0);
    applyStimulus(2, 0, 0, 0, 15, 15, 15, 0);

    // Poison and food on the same cell: poison wins.
    doReset();
    applyStimulus(2, 1, 0, 0, 3, 8, 3, 8);
    applyStimulus(2, 0, 0, 0, 15, 15, 15, 0);

    // Reversal ignored, turn up, run into the top wall, then frozen.
    doReset();
    applyStimulus(2, 0, 1, 2, 15, 15, 15, 0);
    applyStimulus(2, 1, 0, 0, 15, 15, 15, 0);
    applyStimulus(2, 0, 1, 0, 15, 15, 15, 0);
    repeat (11) applyStimulus(2, 1, 0, 0, 15, 15, 15, 0);

    // Grow to 5 and curl back into the body.
    doReset();
    applyStimulus(2, 1, 0, 0, 3, 8, 15, 0);
    applyStimulus(2, 1, 0, 0, 4, 8, 15, 0);
    applyStimulus(2, 0, 1, 1, 15, 15, 15, 0);
    applyStimulus(2, 1, 0, 0, 15, 15, 15, 0);
    applyStimulus(2, 0, 1, 2, 15, 15, 15, 0);
    applyStimulus(2, 1, 0, 0, 15, 15, 15, 0);
    applyStimulus(2, 0, 1, 0, 15, 15, 15, 0);
    applyStimulus(2, 1, 0, 0, 15, 15, 15, 0);
    applyStimulus(2, 1, 0, 0, 15, 15, 15, 0);

    // Length 4 chasing its own vacating tail survives.
    doReset();
    applyStimulus(2, 1, 0, 0, 3, 8, 15, 0);
    applyStimulus(2, 1, 1, 1, 15, 15, 15, 0);
    applyStimulus(2, 1, 1, 2, 15, 15, 15, 0);
    applyStimulus(2, 1, 1, 0, 15, 15, 15, 0);
    applyStimulus(2, 1, 0, 0, 15, 15, 15, 0);

    // Shrink to 1 and eat poison once more; then frozen, then async reset.
    doReset();
    applyStimulus(2, 1, 0, 0, 15, 15, 3, 8);
    applyStimulus(2, 1, 0, 0, 15, 15, 4, 8);
    applyStimulus(2, 1, 0, 0, 15, 15, 5, 8);
    applyStimulus(0, 1, 0, 0, 15, 15, 6, 8);
    applyStimulus(2, 1, 0, 0, 15, 15, 6, 8);
    asyncResetCheck();

    // Randomized episodes with food and poison biased onto the next cell.
    for (int ep = 0; ep < 10; ep++) begin
      doReset();
      for (int n = 0; n < 80 && mDead == 0; n++) begin
        aheadOf(ax, ay);
        fx = int'($urandom_range(0, 15)); fy = int'($urandom_range(0, 15));
        px = int'($urandom_range(0, 15)); py = int'($urandom_range(0, 15));
        if (ax >= 0 && ax <= 15 && ay >= 0 && ay <= 15) begin
          if ($urandom_range(0, 2) == 0) begin fx = ax; fy = ay; end
          if ($urandom_range(0, 7) == 0) begin px = ax; py = ay; end
        end
        st  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 2;
        stp = ($urandom_range(0, 3) != 0) ? 1 : 0;
        applyStimulus(st, stp, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      fx, fy, px, py);
      end
      applyStimulus(2, 1, 0, 0, 15, 15, 15, 0);
    end

    applyStimulus(2, 0, 0, 0, 15, 15, 15, 0);
    repeat (3) @(posedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
